// File: rtl/multicycle_cu_pkg.sv
// rtl/multicycle_cu_pkg.sv - shared states, opcodes and datapath field encodings for the multi-cycle control unit
package multicycle_cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_MULDIV  = 3'd5
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    localparam logic [1:0] RD_ALU = 2'b00;
    localparam logic [1:0] RD_MEM = 2'b01;
    localparam logic [1:0] RD_PC4 = 2'b10;

    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_JUMP = 5'b10000;

    function automatic logic [4:0] br_cond(input logic [2:0] funct3);
        return {2'b01, funct3};
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational instruction decode to datapath fields and class; RV32M_EN enables mul/div
module cu_decoder
    import multicycle_cu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  imm_src,
    output logic [1:0]  alu_a_src,
    output logic        alu_b_src,
    output logic [2:0]  dm_ctrl,
    output logic [4:0]  br_op,
    output logic [1:0]  ru_data_src,
    output logic [4:0]  alu_op,
    output logic        legal,
    output cls_t        cls
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Field decode; illegal encodings leave every field at zero.
    always_comb begin
        imm_src     = IMM_I;
        alu_a_src   = A_RS1;
        alu_b_src   = 1'b0;
        dm_ctrl     = 3'b000;
        br_op       = BR_NONE;
        ru_data_src = RD_ALU;
        alu_op      = 5'b00000;
        cls         = CLS_ILLEGAL;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    cls    = CLS_ALU;
                    alu_op = {1'b0, funct7[5], funct3};
                end
`ifdef RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    cls    = CLS_MULDIV;
                    alu_op = {1'b1, 1'b0, funct3};
                end
`endif
            end
            OP_I: begin
                cls       = CLS_ALU;
                alu_b_src = 1'b1;
                // funct7[5] only selects arithmetic shift; for other ops it is immediate data
                alu_op    = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
            end
            OP_LOAD: begin
                cls         = CLS_LOAD;
                alu_b_src   = 1'b1;
                dm_ctrl     = funct3;
                ru_data_src = RD_MEM;
            end
            OP_STORE: begin
                cls       = CLS_STORE;
                imm_src   = IMM_S;
                alu_b_src = 1'b1;
                dm_ctrl   = funct3;
            end
            OP_BRANCH: begin
                cls       = CLS_BRANCH;
                imm_src   = IMM_B;
                alu_a_src = A_PC;
                alu_b_src = 1'b1;
                br_op     = br_cond(funct3);
            end
            OP_JAL: begin
                cls         = CLS_ALU;
                imm_src     = IMM_J;
                alu_a_src   = A_PC;
                alu_b_src   = 1'b1;
                br_op       = BR_JUMP;
                ru_data_src = RD_PC4;
            end
            OP_JALR: begin
                cls         = CLS_ALU;
                alu_b_src   = 1'b1;
                br_op       = BR_JUMP;
                ru_data_src = RD_PC4;
            end
            OP_LUI: begin
                cls       = CLS_ALU;
                imm_src   = IMM_U;
                alu_a_src = A_ZERO;
                alu_b_src = 1'b1;
            end
            OP_AUIPC: begin
                cls       = CLS_ALU;
                imm_src   = IMM_U;
                alu_a_src = A_PC;
                alu_b_src = 1'b1;
            end
            default: ;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with memory timeout and sticky traps; RV32M_EN adds multi-cycle ALU wait
module multicycle_control_unit
    import multicycle_cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_done,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        ru_write,
    output logic [4:0]  alu_op,
    output logic [2:0]  imm_src,
    output logic [1:0]  alu_a_src,
    output logic        alu_b_src,
    output logic        dm_write,
    output logic [2:0]  dm_ctrl,
    output logic [4:0]  br_op,
    output logic [1:0]  ru_data_src,
    output logic        illegal,
    output logic        mem_err,
    output logic [2:0]  state
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic             illegal_q, mem_err_q;
    logic             set_illegal, set_mem_err;
    logic             tmo_hit, dp_en, is_store;

    logic [2:0] dec_imm_src, dec_dm_ctrl;
    logic [1:0] dec_alu_a_src, dec_ru_data_src;
    logic       dec_alu_b_src, dec_legal;
    logic [4:0] dec_br_op, dec_alu_op;
    cls_t       dec_cls;

`ifndef RV32M_EN
    logic unused_alu_done;
    assign unused_alu_done = alu_done;
`endif

    cu_decoder u_decoder (
        .instr       (instr),
        .imm_src     (dec_imm_src),
        .alu_a_src   (dec_alu_a_src),
        .alu_b_src   (dec_alu_b_src),
        .dm_ctrl     (dec_dm_ctrl),
        .br_op       (dec_br_op),
        .ru_data_src (dec_ru_data_src),
        .alu_op      (dec_alu_op),
        .legal       (dec_legal),
        .cls         (dec_cls)
    );

    assign is_store = (dec_cls == CLS_STORE);
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST) && !mem_ready;

    // Datapath fields are only meaningful once the instruction register holds the instruction.
    assign dp_en = !rst && (state_q == S_DECODE || state_q == S_EXEC ||
                            state_q == S_MEM    || state_q == S_WB);

    assign imm_src     = dp_en ? dec_imm_src     : 3'b000;
    assign alu_a_src   = dp_en ? dec_alu_a_src   : 2'b00;
    assign alu_b_src   = dp_en ? dec_alu_b_src   : 1'b0;
    assign dm_ctrl     = dp_en ? dec_dm_ctrl     : 3'b000;
    assign br_op       = dp_en ? dec_br_op       : 5'b00000;
    assign ru_data_src = dp_en ? dec_ru_data_src : 2'b00;
    assign alu_op      = dp_en ? dec_alu_op      : 5'b00000;
    assign illegal     = illegal_q & !rst;
    assign mem_err     = mem_err_q & !rst;
    assign state       = rst ? 3'd0 : state_q;

    // Next-state and per-state enables; reset masks every enable in the same cycle.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        ru_write    = 1'b0;
        dm_write    = 1'b0;
        set_illegal = 1'b0;
        set_mem_err = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmo_hit) begin
                    set_mem_err = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_EXEC: begin
                case (dec_cls)
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
`ifdef RV32M_EN
                    CLS_MULDIV: if (alu_done) state_d = S_WB;
`endif
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dm_write = is_store;
                if (mem_ready) begin
                    pc_write = is_store;
                    state_d  = is_store ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    set_mem_err = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_WB: begin
                ru_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            ru_write = 1'b0;
            dm_write = 1'b0;
        end
    end

    // State register and sticky trap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_mem_err) mem_err_q <= 1'b1;
        end
    end

    // Memory wait counter, restarted whenever a new request phase begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
            tmo_cnt <= '0;
        end else if ((imem_req || dmem_req) && !mem_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule
